// File: rtl/edge_debounce_if.sv
// Signal bundle between the debounce stage and its neighbours.
// Latency: none, wires only.
// Backpressure: none; sync_in is sampled every cycle and outputs are never stalled.
interface edge_debounce_if #(
  parameter int GLITCH_W = 8
);
  logic                sync_in;
  logic                clear_glitch;
  logic                stable_out;
  logic                fall_pulse;
  logic                rise_pulse;
  logic [GLITCH_W-1:0] glitch_count;

  // Drives the line and the clear; observes the debounced results.
  modport master (
    output sync_in,
    output clear_glitch,
    input  stable_out,
    input  fall_pulse,
    input  rise_pulse,
    input  glitch_count
  );

  // The debounce block itself.
  modport slave (
    input  sync_in,
    input  clear_glitch,
    output stable_out,
    output fall_pulse,
    output rise_pulse,
    output glitch_count
  );
endinterface

// File: rtl/edge_debounce.sv
// Debounces an idle-high synchronized line; emits level, fall/rise strobes, glitch count.
// Latency: level and strobe update on the edge sampling the DEBOUNCE_CYCLES-th new-level value.
// Backpressure: none; one sample per cycle, outputs are registered and never stall.
module edge_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  edge_debounce_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GC_ONE = GLITCH_W'(1);

  typedef enum logic [1:0] {
    STABLE_HIGH = 2'd0,
    CHECK_LOW   = 2'd1,
    STABLE_LOW  = 2'd2,
    CHECK_HIGH  = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;

  // Per-edge events decided by the next-state logic.
  logic                accept_fall;
  logic                accept_rise;
  logic                glitch_evt;

  logic                stable_q, stable_nxt;
  logic                fall_q, fall_nxt;
  logic                rise_q, rise_nxt;
  logic [GLITCH_W-1:0] gc_q, gc_nxt;

  // State and run-length counter register; reset abandons any check in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= STABLE_HIGH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state: count consecutive new-level samples, accept at the last one, reject on any return.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    accept_fall = 1'b0;
    accept_rise = 1'b0;
    glitch_evt  = 1'b0;
    case (state_q)
      STABLE_HIGH: begin
        if (!bus.sync_in) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHECK_LOW: begin
        if (bus.sync_in) begin
          state_nxt  = STABLE_HIGH;
          cnt_nxt    = '0;
          glitch_evt = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt   = STABLE_LOW;
          cnt_nxt     = '0;
          accept_fall = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      STABLE_LOW: begin
        if (bus.sync_in) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!bus.sync_in) begin
          state_nxt  = STABLE_LOW;
          cnt_nxt    = '0;
          glitch_evt = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt   = STABLE_HIGH;
          cnt_nxt     = '0;
          accept_rise = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_HIGH;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output next values: level moves only on acceptance, strobes mirror acceptance, count saturates.
  always_comb begin
    stable_nxt = stable_q;
    if (accept_fall) stable_nxt = 1'b0;
    if (accept_rise) stable_nxt = 1'b1;
    fall_nxt = accept_fall;
    rise_nxt = accept_rise;
    gc_nxt   = gc_q;
    if (bus.clear_glitch) begin
      gc_nxt = '0;
    end else if (glitch_evt && (gc_q != '1)) begin
      gc_nxt = gc_q + GC_ONE;
    end
  end

  // Output registers, so nothing combinational reaches the ports from sync_in.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stable_q <= 1'b1;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
      gc_q     <= '0;
    end else begin
      stable_q <= stable_nxt;
      fall_q   <= fall_nxt;
      rise_q   <= rise_nxt;
      gc_q     <= gc_nxt;
    end
  end

  assign bus.stable_out   = stable_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.glitch_count = gc_q;

endmodule

// File: tb/tb_edge_debounce.sv
// Bench for edge_debounce: reference model feeds a scoreboard, plus directed checks.
// Latency: expectations are taken one edge after each sample is driven.
// Backpressure: not applicable.
module tb_edge_debounce;

  localparam int DEB  = 4;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  edge_debounce_if #(.GLITCH_W(GW)) bus ();

  edge_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .GLITCH_W        (GW)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic stable;
    logic fall;
    logic rise;
    int   gc;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int fall_seen = 0;
  int rise_seen = 0;

  // Reference model: current accepted level and length of the current run that disagrees with it.
  logic m_stable;
  int   m_run;
  int   m_gc;
  logic m_fall;
  logic m_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_stable = 1'b1;
    m_run    = 0;
    m_gc     = 0;
    m_fall   = 1'b0;
    m_rise   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic clr);
    logic glitch;
    glitch = 1'b0;
    m_fall = 1'b0;
    m_rise = 1'b0;
    if (s != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = s;
        m_run    = 0;
        if (s) m_rise = 1'b1;
        else   m_fall = 1'b1;
      end
    end else begin
      if (m_run > 0) glitch = 1'b1;
      m_run = 0;
    end
    if (clr)                         m_gc = 0;
    else if (glitch && m_gc < GMAX)  m_gc = m_gc + 1;
  endtask

  // One sample: drive on the falling edge, model the rising edge, compare just after it.
  task automatic cyc(input logic s, input logic clr = 1'b0);
    exp_t e;
    @(negedge clk);
    bus.sync_in      = s;
    bus.clear_glitch = clr;
    @(posedge clk);
    model_step(s, clr);
    e.stable = m_stable;
    e.fall   = m_fall;
    e.rise   = m_rise;
    e.gc     = m_gc;
    exp_q.push_back(e);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("stable_out",   32'(bus.stable_out),   32'(e.stable));
      chk("fall_pulse",   32'(bus.fall_pulse),   32'(e.fall));
      chk("rise_pulse",   32'(bus.rise_pulse),   32'(e.rise));
      chk("glitch_count", 32'(bus.glitch_count), 32'(e.gc));
      chk("strobe_excl",  32'(bus.fall_pulse & bus.rise_pulse), 32'd0);
    end
    fall_seen += int'(bus.fall_pulse);
    rise_seen += int'(bus.rise_pulse);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    chk("rst_stable", 32'(bus.stable_out),   32'd1);
    chk("rst_fall",   32'(bus.fall_pulse),   32'd0);
    chk("rst_rise",   32'(bus.rise_pulse),   32'd0);
    chk("rst_gc",     32'(bus.glitch_count), 32'd0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst            = 1'b0;
    bus.sync_in      = 1'b1;
    bus.clear_glitch = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    n_rst = 1'b1;

    // Reset while a low check is in progress, sync_in held low.
    for (int i = 0; i < 3; i++) cyc(1'b0);
    do_reset();
    cyc(1'b1);
    chk("t1_stable", 32'(bus.stable_out), 32'd1);

    // Clean fall after four low samples.
    fall_seen = 0;
    for (int i = 0; i < 5; i++) cyc(1'b0);
    chk("t2_fall_cnt", 32'(fall_seen),        32'd1);
    chk("t2_stable",   32'(bus.stable_out),   32'd0);
    chk("t2_gc",       32'(bus.glitch_count), 32'd0);

    // Three-sample high glitch from the low level is rejected.
    rise_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0);
    chk("t3_rise_cnt", 32'(rise_seen),        32'd0);
    chk("t3_stable",   32'(bus.stable_out),   32'd0);
    chk("t3_gc",       32'(bus.glitch_count), 32'd1);

    // Return high, then saturate the glitch counter with two-cycle low glitches.
    for (int i = 0; i < 5; i++) cyc(1'b1);
    cyc(1'b1, 1'b1);
    fall_seen = 0;
    rise_seen = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b1);
    end
    chk("t4_gc_sat",   32'(bus.glitch_count), 32'(GMAX));
    chk("t4_stable",   32'(bus.stable_out),   32'd1);
    chk("t4_strobes",  32'(fall_seen + rise_seen), 32'd0);

    // Clear wins over a glitch landing on the same edge.
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0);
      cyc(1'b1);
    end
    chk("t5_gc7", 32'(bus.glitch_count), 32'd7);
    cyc(1'b0);
    cyc(1'b1, 1'b1);
    chk("t5_clear_win", 32'(bus.glitch_count), 32'd0);
    cyc(1'b0);
    cyc(1'b1);
    chk("t5_after", 32'(bus.glitch_count), 32'd1);

    // Toggling every cycle: each return to the stable level counts once.
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(i[0] ? 1'b1 : 1'b0);
    chk("toggle_gc", 32'(bus.glitch_count), 32'd5);

    // Reset three samples into a low check, then a full low run.
    cyc(1'b1);
    fall_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    do_reset();
    chk("t6_no_fall", 32'(fall_seen), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0);
    chk("t6_fall_now", 32'(bus.fall_pulse), 32'd1);
    cyc(1'b0);
    chk("t6_fall_cnt", 32'(fall_seen),      32'd1);
    chk("t6_stable",   32'(bus.stable_out), 32'd0);

    // Random runs of varying length against the model.
    for (int i = 0; i < 200; i++) begin
      logic s;
      int   len;
      s   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) cyc(s, ($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
